// File: rtl/bcd_stopwatch.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch
//
// Fully synchronous BCD stopwatch / countdown timer for the display datapath.
// The system clock is divided internally into a count tick, so no derived
// clocks exist. The packed BCD count runs up (stopwatch, wraps with an ovf
// pulse) or down (timer, stops at zero in the EXPIRED state).
//
// Optional feature macro: BCD_STOPWATCH_LAP_EN
//   Defined   : a lap pulse while running toggles a display hold. The count
//               keeps running underneath the held value.
//   Undefined : lap is ignored and digits always show the live count.
//
// Parameters
//   DIGITS     number of BCD digits (1..8); digit 0 is least significant
//   TICK_DIV   clk cycles per count tick (>= 2)
//
// Ports
//   clk         in   system clock, rising edge
//   clear       in   synchronous active-high reset
//   start_stop  in   single-cycle pulse, toggles run/stop
//   up          in   1 = count up, 0 = count down (sampled on each tick)
//   load        in   single-cycle pulse, presets count (STOPPED/EXPIRED only)
//   load_value  in   packed BCD preset, nibbles > 9 saturate to 9
//   lap         in   single-cycle pulse, toggles display hold (lap builds)
//   digits      out  packed BCD display value
//   running     out  high in RUNNING
//   ovf         out  one-cycle pulse on an all-9s -> all-0s wrap
//   done        out  high in EXPIRED
// -----------------------------------------------------------------------------
module bcd_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start_stop,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                lap,
  output logic [4*DIGITS-1:0] digits,
  output logic                running,
  output logic                ovf,
  output logic                done
);

  localparam int W     = 4 * DIGITS;
  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // BCD helpers. Inputs are always valid BCD, so digit arithmetic never sees
  // values above 9.
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] f_bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] f_bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] f_bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [W-1:0]     r_count;
  logic [DIV_W-1:0] r_div;
  logic             r_ovf;

  state_t           w_state_nxt;
  logic [W-1:0]     w_count_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_ovf_nxt;
  logic             w_tick;
  logic [W-1:0]     w_inc;
  logic [W-1:0]     w_dec;

  assign w_tick = (r_state == ST_RUNNING) && (r_div == DIV_LAST);
  assign w_inc  = f_bcd_inc(r_count);
  assign w_dec  = f_bcd_dec(r_count);

  // NOTE: clear is sampled on the clock edge only; every register in this
  // block (there is no memory array) returns to its reset value through it.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= ST_STOPPED;
      r_count <= '0;
      r_div   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_div   <= w_div_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state / datapath logic. Priority within a cycle: load, then
  // start_stop, then the tick; clear is handled in the register process.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_div_nxt   = r_div;
    w_ovf_nxt   = 1'b0;

    unique case (r_state)
      ST_STOPPED: begin
        if (load) begin
          w_count_nxt = f_bcd_sat(load_value);
          w_div_nxt   = '0;
        end else if (start_stop) begin
          if (!up && (r_count == '0)) begin
            w_state_nxt = ST_EXPIRED;
          end else begin
            w_state_nxt = ST_RUNNING;
            w_div_nxt   = '0;
          end
        end
      end

      ST_RUNNING: begin
        // load is ignored while running. A stop coinciding with a tick wins:
        // the tick is discarded and div stays at its last value.
        if (start_stop) begin
          w_state_nxt = ST_STOPPED;
        end else if (w_tick) begin
          w_div_nxt = '0;
          if (up) begin
            w_count_nxt = w_inc;
            // Only all-9s increments to all-0s.
            w_ovf_nxt   = (w_inc == '0);
          end else if (r_count == '0) begin
            // Reachable after an up-wrap to zero followed by a direction
            // change; the count never goes below zero.
            w_state_nxt = ST_EXPIRED;
          end else begin
            w_count_nxt = w_dec;
            if (w_dec == '0) w_state_nxt = ST_EXPIRED;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      ST_EXPIRED: begin
        if (load) begin
          w_state_nxt = ST_STOPPED;
          w_count_nxt = f_bcd_sat(load_value);
          w_div_nxt   = '0;
        end else if (start_stop) begin
          w_state_nxt = ST_STOPPED;
        end
      end

      default: begin
        w_state_nxt = ST_STOPPED;
      end
    endcase
  end

  assign running = (r_state == ST_RUNNING);
  assign done    = (r_state == ST_EXPIRED);
  assign ovf     = r_ovf;

  // ---------------------------------------------------------------------------
  // Lap hold
  // ---------------------------------------------------------------------------
`ifdef BCD_STOPWATCH_LAP_EN
  logic         r_hold;
  logic [W-1:0] r_lap;
  logic         w_lap_toggle;
  logic         w_hold_release;

  // lap loses to a same-cycle start_stop; load only acts outside RUNNING, so
  // it never competes with a lap toggle.
  assign w_lap_toggle   = (r_state == ST_RUNNING) && lap && !start_stop;
  assign w_hold_release = load && (r_state != ST_RUNNING);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_hold <= 1'b0;
      r_lap  <= '0;
    end else if (w_hold_release) begin
      r_hold <= 1'b0;
    end else if (w_lap_toggle) begin
      r_hold <= ~r_hold;
      // Capture only when entering hold; the live count shows on release.
      if (!r_hold) r_lap <= r_count;
    end
  end

  assign digits = r_hold ? r_lap : r_count;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign digits       = r_count;
`endif

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Parametrised, fully synchronous BCD stopwatch/timer for the display datapath. It divides the system clock into a count tick internally, so no derived clocks are used. It counts a DIGITS-wide packed BCD value up (stopwatch) or down (countdown timer to zero), with start/stop, preset load, overflow and expiry flags, and an optional lap-hold display. Its output feeds the seven-segment digit multiplexer directly.

## Interface
- DIGITS, 4: number of BCD digits; digit 0 is the least significant (thousandths in the 4-digit stopwatch build); range 1–8.
- TICK_DIV, 50000: clk cycles per LSB count tick; range ≥2.
- clk  in  1  system clock; all logic on rising edge.
- clear  in  1  synchronous, active-high reset.
- start_stop  in  1  single-cycle pulse; toggles run/stop.
- up  in  1  1 = count up, 0 = count down; sampled on each tick.
- load  in  1  single-cycle pulse; presets count from load_value.
- load_value  in  4*DIGITS  packed BCD preset.
- lap  in  1  single-cycle pulse; toggles display hold (LAP_EN builds only).
- digits  out  4*DIGITS  packed BCD display value.
- running  out  1  high in RUNNING state.
- ovf  out  1  one-cycle pulse when an up-count wraps from all-9s to all-0s.
- done  out  1  level; high in EXPIRED state.

## Operation
- State machine: STOPPED, RUNNING, EXPIRED. Reset state: STOPPED.
- Input priority per cycle: clear > load > start_stop > lap.
- STOPPED + start_stop:
  - If up=0 and count==0, go to EXPIRED.
  - Otherwise go to RUNNING.
- RUNNING + start_stop: go to STOPPED.
- RUNNING + down tick producing count==0: go to EXPIRED.
- EXPIRED + start_stop or load: go to STOPPED. The load also applies its value.
- load is accepted only in STOPPED and EXPIRED; it is ignored in RUNNING.
- Any load_value nibble >9 is saturated to 9 on load.
- Prescaler: div counts 0..TICK_DIV-1 only in RUNNING.
  - div is held when not running.
  - div is cleared to 0 by clear, by load, and by the start_stop that enters RUNNING.
  - tick = RUNNING && div==TICK_DIV-1.
- Up tick: digit i increments if all lower digits ==9. A digit at 9 that increments becomes 0. All-9s wraps to all-0s, pulses ovf, and keeps running.
- Down tick: digit i decrements if all lower digits ==0. A digit at 0 that decrements becomes 9. Reaching all-0s enters EXPIRED. The count never wraps below 0.
- Digits always hold valid BCD (0–9).
- Reset values: count 0, div 0, digits 0, running 0, ovf 0, done 0, hold 0.

## Timing
- start_stop accepted at edge E: running=1 from E. The first count change is visible TICK_DIV cycles after E; later changes follow every TICK_DIV cycles.
- A stop and a tick in the same cycle: stop wins and the tick is discarded. The count is unchanged and div holds TICK_DIV-1, so a restart clears it.
- Restart after stop resumes from the held count with div=0.
- ovf and the EXPIRED transition occur on the same edge as the count update that causes them. done rises with the all-0s digits.
- load updates digits on the edge after the pulse (1-cycle latency).
- clear during any state returns everything to reset values on the next edge.
- A change of up mid-run takes effect at the next tick.

## Configuration
- Macro: BCD_STOPWATCH_LAP_EN.
- Defined:
  - A lap pulse in RUNNING toggles hold.
  - Entering hold captures the current count into lap_reg.
  - digits = hold ? lap_reg : count.
  - The count continues underneath the hold.
  - Stopping does not release hold; load or clear releases it.
  - lap is ignored outside RUNNING.
- Undefined: lap is ignored, no lap_reg is built, and digits = count always.

## Test plan
All scenarios use DIGITS=4, TICK_DIV=4.
- Reset and start: clear, then start_stop pulse at edge E -> running=1; digits=0000 until E+4, then 0001, 0002 at E+8; after 10 ticks digits=0010 (carry into digit 1).
- Up wrap: load 9998, start -> 9999 after 4 cycles, then 0000 with a one-cycle ovf on that edge; running stays 1.
- Down expiry: up=0, load 0002, start -> 0001, then 0000 with done=1 and running=0 on the same edge. The next start_stop -> STOPPED, done=0.
- Stop/tick collision and restart: stop pulse in the cycle where div==3 -> count unchanged; restart -> next change exactly 4 cycles later.
- Load rules: load A5F3 while STOPPED -> digits=9593; load during RUNNING -> ignored; clear mid-run -> all outputs 0, STOPPED.
- Lap (BCD_STOPWATCH_LAP_EN defined): lap at count 0005 -> digits frozen at 0005 while the count advances; a second lap at internal 0009 -> digits=0009 immediately. Repeat with the macro undefined -> digits never freeze.
